ym_cnt_bank_tdm: RTL and testbench

Time-division-multiplexed counter bank: CHANNELS independent DATA_WIDTH-bit counters held in one circulating two-phase shift register, one channel presented per slot. It is the parametrised successor to the single-slot `ym_cnt_bit*` cells, adding:
- selectable up/down counting
- optional saturation
- load and clear with defined priority
- a slot index aligned by a sync marker
- synchronous reset

It serves channel-serial engines (FM operator/channel timers, VDP slot counters) that today chain single-bit cells by hand.

---
 rtl/ym_cnt_bank_tdm.sv | 126 ++++++++++++
 tb/tb_ym_cnt_bank_tdm.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ym_cnt_bank_tdm.sv
// ym_cnt_bank_tdm
//
// Time-division-multiplexed counter bank. CHANNELS independent DATA_WIDTH-bit
// counters circulate through a two-phase (master/slave) shift register. The
// last slave stage is the channel currently presented. Its next value is
// computed combinationally and fed back into the first master stage. A slot
// index tracks which channel is on val and can be realigned by a sync marker.
//
// Ports:
//   MCLK      master clock, all state updates on its rising edge
//   reset     synchronous active-high reset, clears masters, slaves and slot
//   c1        phase-1 enable: masters capture (m[0] <= next, m[k] <= s[k-1])
//   c2        phase-2 enable: slaves capture masters, slot index advances
//   sync      slot-0 marker, sampled on c2 cycles
//   c_in      count enable for the channel on val
//   dec       1 = count down, 0 = count up
//   clr       force the current channel's next value to 0
//   load      replace the current channel's base value with load_val
//   load_val  load data
//   val       current channel value (last slave stage)
//   slot      index of the channel shown on val
//   c_out     carry (up) / borrow (down) of the current operation
//   zero      val == 0

module ym_cnt_bank_tdm #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 6,
    parameter int SATURATE   = 0,
    parameter int SLOT_W     = $clog2(CHANNELS)
) (
    input  logic                  MCLK,
    input  logic                  reset,
    input  logic                  c1,
    input  logic                  c2,
    input  logic                  sync,
    input  logic                  c_in,
    input  logic                  dec,
    input  logic                  clr,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_val,
    output logic [DATA_WIDTH-1:0] val,
    output logic [SLOT_W-1:0]     slot,
    output logic                  c_out,
    output logic                  zero
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CHANNELS - 1);

    logic [DATA_WIDTH-1:0] m_q [CHANNELS];
    logic [DATA_WIDTH-1:0] s_q [CHANNELS];
    logic [SLOT_W-1:0]     slot_q;
    logic [SLOT_W-1:0]     slot_d;

    logic [DATA_WIDTH-1:0] base;
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   diff;
    logic                  carry;
    logic [DATA_WIDTH-1:0] result;
    logic [DATA_WIDTH-1:0] next_d;
    logic                  c_out_d;

    // Next value of the presented channel. The extra top bit of sum/diff is
    // the carry or borrow; in down mode it is set exactly when base is 0 and
    // c_in is 1. Clear overrides both the value and the carry indication.
    always_comb begin
        base    = load ? load_val : s_q[CHANNELS-1];
        sum     = {1'b0, base} + {{DATA_WIDTH{1'b0}}, c_in};
        diff    = {1'b0, base} - {{DATA_WIDTH{1'b0}}, c_in};
        carry   = dec ? diff[DATA_WIDTH] : sum[DATA_WIDTH];
        result  = dec ? diff[DATA_WIDTH-1:0] : sum[DATA_WIDTH-1:0];
        next_d  = result;
        c_out_d = carry;
        if ((SATURATE != 0) && carry) begin
            result = dec ? '0 : '1;
            next_d = result;
        end
        if (clr) begin
            next_d  = '0;
            c_out_d = 1'b0;
        end
    end

    // Slot index: sync forces slot 0 regardless of the current position,
    // otherwise it wraps after the last channel.
    always_comb begin
        slot_d = slot_q;
        if (sync) begin
            slot_d = '0;
        end else if (slot_q == LAST_SLOT) begin
            slot_d = '0;
        end else begin
            slot_d = slot_q + SLOT_W'(1);
        end
    end

    // Two-phase shift register. When c1 and c2 are both high the slaves take
    // the masters' old contents, so a channel never skips a stage.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            for (int k = 0; k < CHANNELS; k++) begin
                m_q[k] <= '0;
                s_q[k] <= '0;
            end
            slot_q <= '0;
        end else begin
            if (c1) begin
                m_q[0] <= next_d;
                for (int k = 1; k < CHANNELS; k++) begin
                    m_q[k] <= s_q[k-1];
                end
            end
            if (c2) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    s_q[k] <= m_q[k];
                end
                slot_q <= slot_d;
            end
        end
    end

    assign val   = s_q[CHANNELS-1];
    assign slot  = slot_q;
    assign c_out = c_out_d;
    assign zero  = (s_q[CHANNELS-1] == '0);

endmodule

// File: tb/tb_ym_cnt_bank_tdm.sv
// Testbench for ym_cnt_bank_tdm. Two instances with 4-bit counters and six
// channels share all inputs: one wraps, one saturates. The reference model
// treats the bank as a ring of channel values (a queue) that rotates by one
// each slot period, with the presented value replaced by its next value.

module tb_ym_cnt_bank_tdm;

    localparam int DW   = 4;
    localparam int CH   = 6;
    localparam int SW   = 3;
    localparam int MAXV = 15;

    logic          MCLK = 1'b0;
    logic          reset;
    logic          c1;
    logic          c2;
    logic          sync;
    logic          cIn;
    logic          decr;
    logic          clrIn;
    logic          loadIn;
    logic [DW-1:0] loadVal;

    logic [DW-1:0] valW, valS;
    logic [SW-1:0] slotW, slotS;
    logic          coutW, coutS, zeroW, zeroS;

    int errors = 0;
    int checks = 0;

    int qW[$];
    int qS[$];
    int mSlot;

    logic [DW-1:0] obsValW, obsValS;
    logic [SW-1:0] obsSlotW;
    logic          obsCoutW, obsCoutS;
    logic [17:0]   obsPack;
    logic [17:0]   expPack;

    always #5 MCLK = ~MCLK;

    ym_cnt_bank_tdm #(.DATA_WIDTH(DW), .CHANNELS(CH), .SATURATE(0)) dutW (
        .MCLK(MCLK), .reset(reset), .c1(c1), .c2(c2), .sync(sync),
        .c_in(cIn), .dec(decr), .clr(clrIn), .load(loadIn), .load_val(loadVal),
        .val(valW), .slot(slotW), .c_out(coutW), .zero(zeroW)
    );

    ym_cnt_bank_tdm #(.DATA_WIDTH(DW), .CHANNELS(CH), .SATURATE(1)) dutS (
        .MCLK(MCLK), .reset(reset), .c1(c1), .c2(c2), .sync(sync),
        .c_in(cIn), .dec(decr), .clr(clrIn), .load(loadIn), .load_val(loadVal),
        .val(valS), .slot(slotS), .c_out(coutS), .zero(zeroS)
    );

    // Plain-integer counter rule: pick the base, add or subtract, detect
    // leaving the 0..MAXV range, then wrap or clamp; clear wins over all.
    function automatic void modelNext(input int v, input bit cin, input bit dn,
                                      input bit cl, input bit ld, input int lv,
                                      input bit sat, output int nv, output bit co);
        int b;
        int r;
        b  = ld ? lv : v;
        r  = dn ? b - int'(cin) : b + int'(cin);
        co = (r > MAXV) || (r < 0);
        if (co) nv = sat ? (dn ? 0 : MAXV) : (r & MAXV);
        else    nv = r;
        if (cl) begin
            nv = 0;
            co = 1'b0;
        end
    endfunction

    function automatic void modelReset();
        qW.delete();
        qS.delete();
        for (int i = 0; i < CH; i++) begin
            qW.push_back(0);
            qS.push_back(0);
        end
        mSlot = 0;
    endfunction

    // One slot period (c1 cycle, c2 cycle) followed by an idle cycle with
    // random junk on the data inputs. Observed outputs are captured during
    // the c1 cycle; the expectation comes from the model's ring.
    task automatic applyStimulus(input bit cin, input bit dn, input bit cl,
                                 input bit ld, input int lv, input bit sy);
        int nW, nS;
        bit coW, coS;
        modelNext(qW[0], cin, dn, cl, ld, lv, 1'b0, nW, coW);
        modelNext(qS[0], cin, dn, cl, ld, lv, 1'b1, nS, coS);
        expPack = {DW'(qW[0]), SW'(mSlot), coW, (qW[0] == 0),
                   DW'(qS[0]), SW'(mSlot), coS, (qS[0] == 0)};
        @(negedge MCLK);
        c1 = 1'b1; c2 = 1'b0;
        cIn = cin; decr = dn; clrIn = cl; loadIn = ld; loadVal = DW'(lv);
        sync = 1'($urandom);
        #1;
        obsValW  = valW;
        obsValS  = valS;
        obsSlotW = slotW;
        obsCoutW = coutW;
        obsCoutS = coutS;
        obsPack  = {valW, slotW, coutW, zeroW, valS, slotS, coutS, zeroS};
        @(negedge MCLK);
        c1 = 1'b0; c2 = 1'b1; sync = sy;
        @(negedge MCLK);
        c1 = 1'b0; c2 = 1'b0;
        cIn = 1'($urandom); decr = 1'($urandom); clrIn = 1'($urandom);
        loadIn = 1'($urandom); loadVal = DW'($urandom); sync = 1'($urandom);
        void'(qW.pop_front());
        void'(qS.pop_front());
        qW.push_back(nW);
        qS.push_back(nS);
        mSlot = sy ? 0 : (mSlot + 1) % CH;
    endtask

    task automatic gotoSlot(input int n);
        for (int i = 0; i < CH && mSlot != n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; c1 = 1'b1; c2 = 1'b1; sync = 1'b0;
        cIn = 1'b0; decr = 1'b0; clrIn = 1'b0; loadIn = 1'b0; loadVal = '0;
        repeat (2) @(negedge MCLK);
        reset = 1'b0; c1 = 1'b0; c2 = 1'b0; cIn = 1'b1; decr = 1'b1;
        #1;
        checks++;
        if ({valW, slotW, zeroW, coutW, valS, slotS, zeroS, coutS} !==
            {4'd0, 3'd0, 1'b1, 1'b1, 4'd0, 3'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL reset_state got val=%0d/%0d slot=%0d zero=%b/%b cout=%b/%b want 0 0 1 1",
                     valW, valS, slotW, zeroW, zeroS, coutW, coutS);
        end
        decr = 1'b0;
        #1;
        checks++;
        if ({coutW, coutS} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_cout_up got %b%b want 00", coutW, coutS);
        end
        modelReset();
    endtask

    task automatic test_count();
        for (int p = 0; p < 10 * CH; p++) begin
            applyStimulus(mSlot == 2, 1'b0, 1'b0, 1'b0, 0, 1'b0);
            checks++;
            if (obsPack !== expPack) begin
                errors++;
                $display("[TB] FAIL count p=%0d got %h want %h", p, obsPack, expPack);
            end
            checks++;
            if (obsSlotW !== SW'(p % CH)) begin
                errors++;
                $display("[TB] FAIL slot_seq p=%0d got %0d want %0d", p, obsSlotW, p % CH);
            end
        end
        for (int p = 0; p < CH; p++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
            checks++;
            if ({obsValW, obsValS} !== {DW'(p == 2 ? 10 : 0), DW'(p == 2 ? 10 : 0)}) begin
                errors++;
                $display("[TB] FAIL count_total slot=%0d got %0d/%0d want %0d",
                         p, obsValW, obsValS, (p == 2 ? 10 : 0));
            end
        end
    endtask

    task automatic test_wrap_saturate_up();
        gotoSlot(0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 15, 1'b0);
        checks++;
        if ({obsCoutW, obsCoutS, obsPack} !== {2'b11, expPack}) begin
            errors++;
            $display("[TB] FAIL wrap_load_carry got cout=%b%b %h want 11 %h",
                     obsCoutW, obsCoutS, obsPack, expPack);
        end
        gotoSlot(0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        checks++;
        if ({obsValW, obsValS, obsCoutW, obsCoutS} !== {4'd0, 4'd15, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL wrap_value got val=%0d/%0d cout=%b%b want 0/15 01",
                     obsValW, obsValS, obsCoutW, obsCoutS);
        end
        gotoSlot(0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        checks++;
        if ({obsValW, obsValS} !== {4'd1, 4'd15}) begin
            errors++;
            $display("[TB] FAIL sat_up_hold got %0d/%0d want 1/15", obsValW, obsValS);
        end
    endtask

    task automatic test_saturate_down();
        gotoSlot(1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        checks++;
        if ({obsCoutW, obsCoutS, obsPack} !== {2'b11, expPack}) begin
            errors++;
            $display("[TB] FAIL borrow got cout=%b%b %h want 11 %h",
                     obsCoutW, obsCoutS, obsPack, expPack);
        end
        gotoSlot(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        checks++;
        if ({obsValW, obsValS} !== {4'd15, 4'd0}) begin
            errors++;
            $display("[TB] FAIL sat_down got %0d/%0d want 15/0", obsValW, obsValS);
        end
    endtask

    task automatic test_clr_load();
        gotoSlot(3);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 7, 1'b0);
        checks++;
        if ({obsCoutW, obsCoutS} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL clr_cout got %b%b want 00", obsCoutW, obsCoutS);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 7, 1'b0);
        gotoSlot(3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        checks++;
        if ({obsValW, obsValS} !== {4'd0, 4'd0}) begin
            errors++;
            $display("[TB] FAIL clr_over_load got %0d/%0d want 0/0", obsValW, obsValS);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        checks++;
        if ({obsValW, obsValS} !== {4'd8, 4'd8}) begin
            errors++;
            $display("[TB] FAIL load_count got %0d/%0d want 8/8", obsValW, obsValS);
        end
    endtask

    task automatic test_sync();
        gotoSlot(3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        checks++;
        if ({obsSlotW, obsValW, obsValS} !== {3'd0, 4'd8, 4'd8}) begin
            errors++;
            $display("[TB] FAIL sync_realign got slot=%0d val=%0d/%0d want 0 8/8",
                     obsSlotW, obsValW, obsValS);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        checks++;
        if (obsSlotW !== 3'd1) begin
            errors++;
            $display("[TB] FAIL sync_next_slot got %0d want 1", obsSlotW);
        end
    endtask

    // A c1-only cycle with c_in=1, then a c1+c2 cycle with c_in=0. The slaves
    // must take the incremented masters of the first cycle; the second c1
    // capture is overwritten by the next regular period.
    task automatic test_back_to_back();
        int nW, nS;
        bit coW, coS;
        modelNext(qW[0], 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, nW, coW);
        modelNext(qS[0], 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, nS, coS);
        @(negedge MCLK);
        c1 = 1'b1; c2 = 1'b0; cIn = 1'b1; decr = 1'b0; clrIn = 1'b0; loadIn = 1'b0; sync = 1'b0;
        @(negedge MCLK);
        c2 = 1'b1; cIn = 1'b0;
        @(negedge MCLK);
        c1 = 1'b0; c2 = 1'b0;
        void'(qW.pop_front());
        void'(qS.pop_front());
        qW.push_back(nW);
        qS.push_back(nS);
        mSlot = (mSlot + 1) % CH;
        #1;
        checks++;
        if ({valW, valS, slotW} !== {DW'(qW[0]), DW'(qS[0]), SW'(mSlot)}) begin
            errors++;
            $display("[TB] FAIL simul_shift got val=%0d/%0d slot=%0d want %0d/%0d %0d",
                     valW, valS, slotW, qW[0], qS[0], mSlot);
        end
        for (int i = 0; i < CH; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
            checks++;
            if (obsPack !== expPack) begin
                errors++;
                $display("[TB] FAIL simul_rotate i=%0d got %h want %h", i, obsPack, expPack);
            end
        end
    endtask

    task automatic test_midreset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 9, 1'b0);
        @(negedge MCLK);
        reset = 1'b1; c1 = 1'b1; c2 = 1'b1; cIn = 1'b1; decr = 1'b1; clrIn = 1'b0; loadIn = 1'b1;
        @(negedge MCLK);
        reset = 1'b0; c1 = 1'b0; c2 = 1'b0; loadIn = 1'b0;
        #1;
        checks++;
        if ({valW, slotW, zeroW, coutW, valS, slotS, zeroS, coutS} !==
            {4'd0, 3'd0, 1'b1, 1'b1, 4'd0, 3'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL midreset got val=%0d/%0d slot=%0d zero=%b/%b cout=%b/%b want 0 0 1 1",
                     valW, valS, slotW, zeroW, zeroS, coutW, coutS);
        end
        modelReset();
        for (int i = 0; i < 2 * CH; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
            checks++;
            if (obsPack !== expPack) begin
                errors++;
                $display("[TB] FAIL after_reset i=%0d got %h want %h", i, obsPack, expPack);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 250; i++) begin
            applyStimulus(1'($urandom), 1'($urandom),
                          $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                          int'($urandom_range(0, MAXV)), $urandom_range(0, 19) == 0);
            checks++;
            if (obsPack !== expPack) begin
                errors++;
                $display("[TB] FAIL random i=%0d got %h want %h", i, obsPack, expPack);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap_saturate_up();
        test_saturate_down();
        test_clr_load();
        test_sync();
        test_back_to_back();
        test_midreset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
